// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// master: controller side (takes instruction fields and MemReady, drives controls).
// slave: datapath side (drives instruction fields and MemReady, takes controls).
interface multicycle_controller_if;
    logic [5:0]  Opcode;      // instruction register [31:26]
    logic [5:0]  Funct;       // instruction register [5:0]
    logic        MemReady;    // memory finishes the current access this cycle
    logic [2:0]  State;       // IF=0 ID=1 EXE=2 MEM=3 WB=4 HALT=5
    logic        PCWrite;
    logic        Jump;
    logic        Branch;
    logic        Expect;
    logic        IRWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        RegDst;
    logic        MemToReg;
    logic        ALUSrcB;
    logic        ExtSel;
    logic [2:0]  ALUOp;       // 0 add, 1 sub, 2 or, 3 and, 4 slt
    logic        Halted;
    logic [31:0] InstrCount;  // retired-instruction count

    modport master (
        input  Opcode, Funct, MemReady,
        output State, PCWrite, Jump, Branch, Expect, IRWrite, MemRead, MemWrite,
               RegWrite, RegDst, MemToReg, ALUSrcB, ExtSel, ALUOp, Halted, InstrCount
    );

    modport slave (
        output Opcode, Funct, MemReady,
        input  State, PCWrite, Jump, Branch, Expect, IRWrite, MemRead, MemWrite,
               RegWrite, RegDst, MemToReg, ALUSrcB, ExtSel, ALUOp, Halted, InstrCount
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: IF/ID/EXE/MEM/WB sequencing of one shared datapath,
// Moore-decoded controls, MemReady stalls in IF and MEM, retired-instruction counter.
// Ports: CLK, Reset (sync, active high), bus (multicycle_controller_if.master).
// Optional HALT state built when MULTICYCLE_HALT_EN is defined; otherwise opcode 111111 is a nop.
module multicycle_controller (
    input  logic                          CLK,
    input  logic                          Reset,
    multicycle_controller_if.master       bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_HALT_EN
    localparam logic [5:0] OP_HALT  = 6'b111111;
`endif

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
`ifdef MULTICYCLE_HALT_EN
        ,
        S_HALT = 3'd5
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q;
    logic [31:0] instr_count;

    logic pc_write, jump, branch, expect_eq, ir_write, mem_read, mem_write;
    logic reg_write, reg_dst, mem_to_reg, alu_src_b, ext_sel;
    logic [2:0] alu_op;

    // R-type funct decode; unknown functs fall back to add
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return ALU_ADD;
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= S_IF;
            op_q        <= 6'd0;
            instr_count <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID)
                op_q <= bus.Opcode;
            if (pc_write)
                instr_count <= instr_count + 32'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        expect_eq  = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        ext_sel    = 1'b0;
        alu_op     = ALU_ADD;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                if (bus.MemReady) begin
                    ir_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            // op_q is loaded at the end of this cycle, so ID decodes the live opcode
            S_ID: begin
                case (bus.Opcode)
                    OP_J: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_IF;
                    end
`ifdef MULTICYCLE_HALT_EN
                    OP_HALT: state_d = S_HALT;
`endif
                    OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE:
                        state_d = S_EXE;
                    default: begin
                        // unknown opcode retires as a nop
                        pc_write = 1'b1;
                        state_d  = S_IF;
                    end
                endcase
            end
            S_EXE: begin
                case (op_q)
                    OP_RTYPE: begin
                        alu_op  = funct_alu(bus.Funct);
                        reg_dst = 1'b1;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src_b = 1'b1;
                        ext_sel   = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_ORI: begin
                        alu_src_b = 1'b1;
                        alu_op    = ALU_OR;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = 1'b1;
                        ext_sel   = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_op    = ALU_SUB;
                        branch    = 1'b1;
                        expect_eq = (op_q == OP_BEQ);
                        pc_write  = 1'b1;
                        state_d   = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                // address computation stays selected for the whole stall
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
                if (op_q == OP_LW) begin
                    mem_read = 1'b1;
                    if (bus.MemReady)
                        state_d = S_WB;
                end else begin
                    mem_write = 1'b1;
                    if (bus.MemReady) begin
                        pc_write = 1'b1;
                        state_d  = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (op_q == OP_LW);
                reg_dst    = (op_q == OP_RTYPE);
                // immediate forms keep their EXE operand selection
                alu_src_b  = (op_q != OP_RTYPE);
                ext_sel    = (op_q == OP_ADDI) || (op_q == OP_LW);
                state_d    = S_IF;
            end
`ifdef MULTICYCLE_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IF;
        endcase

        // reset aborts whatever is in flight: no strobe may escape this cycle
        if (Reset) begin
            state_d    = S_IF;
            pc_write   = 1'b0;
            jump       = 1'b0;
            branch     = 1'b0;
            expect_eq  = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_b  = 1'b0;
            ext_sel    = 1'b0;
            alu_op     = ALU_ADD;
        end
    end

    assign bus.State      = state_q;
    assign bus.PCWrite    = pc_write;
    assign bus.Jump       = jump;
    assign bus.Branch     = branch;
    assign bus.Expect     = expect_eq;
    assign bus.IRWrite    = ir_write;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.RegWrite   = reg_write;
    assign bus.RegDst     = reg_dst;
    assign bus.MemToReg   = mem_to_reg;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ExtSel     = ext_sel;
    assign bus.ALUOp      = alu_op;
    assign bus.InstrCount = instr_count;
`ifdef MULTICYCLE_HALT_EN
    assign bus.Halted     = (state_q == S_HALT);
`else
    assign bus.Halted     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state and control-vector checks
// against hand-computed expectations, plus retired-instruction count checkpoints.
module tb_multicycle_controller;
    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // control vector layout: {PCWrite,Jump,Branch,Expect,IRWrite,MemRead,MemWrite,
    //                         RegWrite,RegDst,MemToReg,ALUSrcB,ExtSel,ALUOp[2:0],Halted}
    localparam logic [15:0] PCW = 16'h8000;
    localparam logic [15:0] JMP = 16'h4000;
    localparam logic [15:0] BR  = 16'h2000;
    localparam logic [15:0] EXP = 16'h1000;
    localparam logic [15:0] IRW = 16'h0800;
    localparam logic [15:0] MR  = 16'h0400;
    localparam logic [15:0] MW  = 16'h0200;
    localparam logic [15:0] RW  = 16'h0100;
    localparam logic [15:0] RD  = 16'h0080;
    localparam logic [15:0] MTR = 16'h0040;
    localparam logic [15:0] SB  = 16'h0020;
    localparam logic [15:0] EX  = 16'h0010;
    localparam logic [15:0] HLT = 16'h0001;

    function automatic logic [15:0] alu(input logic [2:0] n);
        return {12'd0, n, 1'b0};
    endfunction

    function automatic logic [15:0] ctl_obs();
        return {bus.PCWrite, bus.Jump, bus.Branch, bus.Expect, bus.IRWrite, bus.MemRead,
                bus.MemWrite, bus.RegWrite, bus.RegDst, bus.MemToReg, bus.ALUSrcB,
                bus.ExtSel, bus.ALUOp, bus.Halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inputs are set just after a rising edge; outputs are checked 1ns later, then one cycle elapses
    task automatic cyc(input string tag, input logic [2:0] st, input logic [15:0] c);
        #1;
        chk({tag, " state"}, {29'd0, bus.State}, {29'd0, st});
        chk({tag, " ctl"}, {16'd0, ctl_obs()}, {16'd0, c});
        @(posedge CLK);
        #1;
    endtask

    task automatic rtype(input string tag, input logic [5:0] f, input logic [2:0] op);
        bus.Opcode = 6'b000000;
        bus.Funct  = f;
        cyc({tag, "_if"},  3'd0, IRW | MR);
        cyc({tag, "_id"},  3'd1, 16'h0);
        cyc({tag, "_exe"}, 3'd2, RD | alu(op));
        cyc({tag, "_wb"},  3'd4, PCW | RW | RD);
    endtask

    initial begin
        Reset        = 1'b1;
        bus.MemReady = 1'b0;
        bus.Opcode   = 6'd0;
        bus.Funct    = 6'd0;

        // reset held two cycles
        @(posedge CLK); #1;
        #1;
        chk("rst_ctl", {16'd0, ctl_obs()}, 32'd0);
        chk("rst_state", {29'd0, bus.State}, 32'd0);
        @(posedge CLK); #1;
        chk("rst_count", bus.InstrCount, 32'd0);

        // release into a 3-cycle fetch stall
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_count", bus.InstrCount, 32'd0);
            cyc("if_stall", 3'd0, MR);
        end
        // reset during the stall: strobes suppressed, stays in IF
        Reset = 1'b1;
        cyc("rst_in_stall", 3'd0, 16'h0);
        chk("rst_in_stall_count", bus.InstrCount, 32'd0);
        Reset = 1'b0;

        // add
        bus.MemReady = 1'b1;
        bus.Opcode   = 6'b000000;
        bus.Funct    = 6'b100000;
        cyc("add_if",  3'd0, IRW | MR);
        cyc("add_id",  3'd1, 16'h0);
        cyc("add_exe", 3'd2, RD | alu(3'd0));
        chk("add_count_before", bus.InstrCount, 32'd0);
        cyc("add_wb",  3'd4, PCW | RW | RD);
        chk("add_count_after", bus.InstrCount, 32'd1);

        // lw with two MEM stall cycles: 7 cycles total
        bus.Opcode = 6'b100011;
        cyc("lw_if",  3'd0, IRW | MR);
        cyc("lw_id",  3'd1, 16'h0);
        cyc("lw_exe", 3'd2, SB | EX);
        bus.MemReady = 1'b0;
        cyc("lw_mem_stall", 3'd3, MR | SB | EX);
        cyc("lw_mem_stall", 3'd3, MR | SB | EX);
        bus.MemReady = 1'b1;
        cyc("lw_mem", 3'd3, MR | SB | EX);
        chk("lw_count_before", bus.InstrCount, 32'd1);
        cyc("lw_wb",  3'd4, PCW | RW | MTR | SB | EX);
        chk("lw_count", bus.InstrCount, 32'd2);

        // sw: PCWrite together with MemWrite/MemReady, no RegWrite
        bus.Opcode = 6'b101011;
        cyc("sw_if",  3'd0, IRW | MR);
        cyc("sw_id",  3'd1, 16'h0);
        cyc("sw_exe", 3'd2, SB | EX);
        cyc("sw_mem", 3'd3, PCW | MW | SB | EX);
        chk("sw_count", bus.InstrCount, 32'd3);

        // beq / bne
        bus.Opcode = 6'b000100;
        cyc("beq_if",  3'd0, IRW | MR);
        cyc("beq_id",  3'd1, 16'h0);
        cyc("beq_exe", 3'd2, PCW | BR | EXP | alu(3'd1));
        bus.Opcode = 6'b000101;
        cyc("bne_if",  3'd0, IRW | MR);
        cyc("bne_id",  3'd1, 16'h0);
        cyc("bne_exe", 3'd2, PCW | BR | alu(3'd1));
        chk("branch_count", bus.InstrCount, 32'd5);

        // j then unknown opcode
        bus.Opcode = 6'b000010;
        cyc("j_if", 3'd0, IRW | MR);
        cyc("j_id", 3'd1, PCW | JMP);
        bus.Opcode = 6'b010000;
        cyc("nop_if", 3'd0, IRW | MR);
        cyc("nop_id", 3'd1, PCW);
        chk("j_nop_count", bus.InstrCount, 32'd7);

        // ori / addi: immediate selection held into WB
        bus.Opcode = 6'b001101;
        cyc("ori_if",  3'd0, IRW | MR);
        cyc("ori_id",  3'd1, 16'h0);
        cyc("ori_exe", 3'd2, SB | alu(3'd2));
        cyc("ori_wb",  3'd4, PCW | RW | SB);
        bus.Opcode = 6'b001000;
        cyc("addi_if",  3'd0, IRW | MR);
        cyc("addi_id",  3'd1, 16'h0);
        cyc("addi_exe", 3'd2, SB | EX);
        cyc("addi_wb",  3'd4, PCW | RW | SB | EX);
        chk("imm_count", bus.InstrCount, 32'd9);

        // remaining R-type functs, including an unknown one
        rtype("sub", 6'b100010, 3'd1);
        rtype("and", 6'b100100, 3'd3);
        rtype("or",  6'b100101, 3'd2);
        rtype("slt", 6'b101010, 3'd4);
        rtype("badf", 6'b111000, 3'd0);
        chk("rtype_count", bus.InstrCount, 32'd14);

        // halt opcode
        bus.Opcode = 6'b111111;
        cyc("halt_if", 3'd0, IRW | MR);
`ifdef MULTICYCLE_HALT_EN
        cyc("halt_id", 3'd1, 16'h0);
        for (int i = 0; i < 10; i++)
            cyc("halted", 3'd5, HLT);
        chk("halt_count", bus.InstrCount, 32'd14);
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        bus.Opcode = 6'b000000;
        cyc("post_halt_if", 3'd0, IRW | MR);
        chk("post_halt_count", bus.InstrCount, 32'd0);
`else
        cyc("halt_nop_id", 3'd1, PCW);
        chk("halt_nop_count", bus.InstrCount, 32'd15);
        cyc("halt_nop_next", 3'd0, IRW | MR);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // watchdog so a stuck run still terminates
    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM that sequences the single shared datapath: instruction fetch, decode, execute, memory access and write-back. It drives the program counter's `Jump`, `Branch` and `Expect` inputs and a one-cycle `PCWrite` strobe that ends each instruction. It also drives register-file, memory and ALU controls. Memory accesses stall on a ready handshake, and the block keeps a retired-instruction counter.

## Interface
- No parameters. Opcode encodings are fixed MIPS values.
- `CLK` in 1: rising-edge clock.
- `Reset` in 1: synchronous, active-high reset.
- `Opcode` in 6: instruction register bits [31:26]; valid from the ID cycle onward.
- `Funct` in 6: instruction register bits [5:0]; used only for R-type ALU control.
- `MemReady` in 1: memory completes the current read/write this cycle.
- `State` out 3: current state (IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5).
- `PCWrite` out 1: program counter advances this cycle.
- `Jump`, `Branch`, `Expect` out 1 each: program counter next-address select.
- `IRWrite` out 1: load the instruction register.
- `MemRead`, `MemWrite` out 1 each: memory strobes, held until `MemReady`.
- `RegWrite`, `RegDst`, `MemToReg`, `ALUSrcB`, `ExtSel` out 1 each: datapath muxes and enables.
- `ALUOp` out 3: 0=add, 1=sub, 2=or, 3=and, 4=slt.
- `Halted` out 1: high in the HALT state.
- `InstrCount` out 32: retired-instruction count.

## Operation
- Opcodes handled:
  - R-type: 000000, with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, halt 111111.
- `Opcode` is registered internally in ID (`op_q`); later states use `op_q` only.
- Outputs are Moore-decoded from state and `op_q`, plus `MemReady` where stated. Every strobe not listed for a state is 0.
- **IF**
  - `MemRead`=1.
  - If `MemReady`=1: `IRWrite`=1 and go to ID. Otherwise stay in IF.
- **ID**
  - Latch `op_q`.
  - j: `Jump`=1, `PCWrite`=1, go to IF.
  - halt: go to HALT (see Configuration).
  - Unknown opcode: treated as nop. `PCWrite`=1, go to IF.
  - All other opcodes: go to EXE.
- **EXE**
  - R-type: `ALUOp` from funct, `RegDst`=1, go to WB.
  - addi: `ALUSrcB`=1, `ExtSel`=1, `ALUOp`=add, go to WB.
  - ori: `ALUSrcB`=1, `ExtSel`=0, `ALUOp`=or, go to WB.
  - lw/sw: `ALUSrcB`=1, `ExtSel`=1, `ALUOp`=add, go to MEM.
  - beq/bne: `ALUOp`=sub, `Branch`=1, `Expect`=1 for beq and 0 for bne, `PCWrite`=1, go to IF.
  - R-type with an unknown funct: `ALUOp`=add, completes normally.
- **MEM**
  - lw: `MemRead`=1. On `MemReady`, go to WB.
  - sw: `MemWrite`=1. On `MemReady`, `PCWrite`=1 and go to IF.
  - Address mux controls are held for the whole stall.
- **WB**
  - `RegWrite`=1, `PCWrite`=1, go to IF.
  - `MemToReg`=1 for lw.
  - `RegDst`=1 for R-type.
  - Non-R-type: `ALUSrcB`/`ExtSel` hold their EXE values.
- **InstrCount**: increments by 1 in every cycle where `PCWrite`=1. Wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - While `Reset`=1 at a rising edge: next state is IF, `op_q`=0, `InstrCount`=0.
  - All strobe outputs are forced to 0 while `Reset`=1.
  - The first cycle after release is IF with `MemRead`=1.
- Reset asserted mid-instruction (including during a MEM stall) aborts the instruction. No `PCWrite` or `RegWrite` occurs in that cycle.
- Cycles per instruction with `MemReady` tied high: j=2, beq/bne=3, sw=4, R-type/addi/ori=4, lw=5, nop=2.
- Each cycle of `MemReady`=0 in IF or MEM adds exactly one cycle.
- `PCWrite` is exactly one cycle wide per retired instruction.
- `MemRead` and `MemWrite` are never both 1.
- `Jump` and `Branch` are never both 1.

## Configuration
- Macro: `MULTICYCLE_HALT_EN`.
- **Defined**:
  - Opcode 111111 in ID goes to HALT. In HALT all strobes are 0 and `Halted`=1.
  - `PCWrite` is not asserted and `InstrCount` does not change.
  - Only `Reset` leaves HALT.
- **Undefined**:
  - The HALT state is not built and `Halted` is tied to 0.
  - Opcode 111111 executes as a nop (ID: `PCWrite`=1, back to IF).

## Test plan
- **Reset during stall**: reset held 2 cycles, then release with `MemReady`=0 for 3 cycles.
  - State stays IF with `MemRead`=1 for those 3 cycles and `InstrCount`=0.
  - Assert `Reset` during the stall: next cycle is IF with no `PCWrite`.
- **add**: `Opcode`=000000, `Funct`=100000, `MemReady`=1.
  - States IF, ID, EXE, WB.
  - WB has `RegWrite`=1, `RegDst`=1, `PCWrite`=1.
  - `InstrCount` goes 0 to 1.
- **lw then sw**: lw with `MemReady` low for 2 cycles in MEM.
  - lw takes 7 cycles and WB has `MemToReg`=1.
  - sw takes 4 cycles, `PCWrite` coincides with the `MemWrite`/`MemReady` cycle, and `RegWrite` stays 0.
- **beq then bne**:
  - beq: EXE has `Branch`=1, `Expect`=1, `PCWrite`=1; 3 cycles total.
  - bne: `Expect`=0.
- **j then unknown opcode 010000**:
  - j: ID has `Jump`=1, `PCWrite`=1; 2 cycles.
  - 010000: ID has `PCWrite`=1, `Jump`=0.
  - `InstrCount` advances by 2.
- **halt (opcode 111111)**:
  - With `MULTICYCLE_HALT_EN`: State=5 and `Halted`=1 are held for 10 cycles with no strobes. `Reset` returns the FSM to IF.
  - Without the macro: behaves as a nop and `InstrCount` increments.
